sb_tx_pkt_serializer: RTL and testbench
=======================================

// Module: sb_tx_pkt_serializer
// PURPOSE
// - Parametrised sideband transmitter: accepts header + optional 32b/64b data messages over valid/ready.
// - Queues them in a FIFO and serialises each packet on one data lane, each packet followed by a quiet gap.
// - Single clock domain; emits a clock-enable qualifier that the pad wrapper uses to gate the forwarded SB clock.
// PARAMETERS
// - DEPTH    8   FIFO entries (messages); power of 2, >=2
// - PKT_W    64  bits per serial packet; 32b payloads are zero-extended to PKT_W
// - GAP_UI   32  idle UI after every packet; >=1
// PORTS
// - clk_100MHz  in   1        clock; reset is synchronous, active-high
// - reset       in   1        synchronous reset
// - hdr_i       in   PKT_W    encoded header packet
// - data_i      in   64       payload; [31:0] used when dlen_i=1
// - dlen_i      in   2        0=no data, 1=32b, 2=64b, 3=illegal
// - valid_i     in   1        message valid
// - ready_o     out  1        FIFO can accept (= !full && enable_i)
// - enable_i    in   1        link enable; gates accept and new pops
// - data_o      out  1        serial data, LSB first, registered
// - clk_en_o    out  1        high exactly on UIs carrying packet bits
// - busy_o      out  1        state != IDLE || FIFO non-empty
// - level_o     out  clog2(DEPTH)+1  FIFO occupancy
// - err_o       out  1        one-cycle pulse: dlen_i=3 message dropped
// BEHAVIOUR
// - Reset: FIFO flushed, state IDLE; data_o=0, clk_en_o=0, busy_o=0, level_o=0, err_o=0, ready_o=0 while reset high.
// - Reset mid-packet: outputs 0 on the cycle after reset is sampled; queued messages lost.
// - Accept: valid_i && ready_o at edge -> entry {dlen,data,hdr} written; dlen_i=3 -> not written, err_o=1 next cycle.
// - FIFO: circular, wrap-around pointers, one extra bit for full/empty; no push when full (ready_o=0).
// - Pop when state IDLE, FIFO non-empty, enable_i=1; pop and push in same cycle allowed (level unchanged).
// - FSM IDLE -> HDR -> GAP -> (DATA -> GAP) -> IDLE or HDR of next entry.
// - HDR/DATA: PKT_W cycles, data_o = shift_reg[0], clk_en_o=1, shift right each cycle.
// - GAP: GAP_UI cycles, data_o=0, clk_en_o=0; after gap: DATA if pending payload; else next entry popped if
//   non-empty and enable_i, going straight to HDR (no IDLE cycle); else IDLE.
// - Latency: accept at cycle A into empty idle block -> pop at A+1 -> bit0 of header on data_o at A+2.
// - Back-to-back messages: exactly GAP_UI zero-UIs between last bit of one packet and first bit of next.
// - Payload 32b: packet = {32'd0, data[31:0]}; 64b: data[63:0]; packet sent after header's gap.
// - enable_i low: in-flight message (header, gap, data, gap) completes; no further pops; FIFO retained.
// - Counters: bit counter clog2(PKT_W) bits, gap counter clog2(GAP_UI+1) bits, cleared on each state entry.
// CONFIGURATION
// - SB_TX_PKT_COUNT_EN defined: adds port tx_count_o out 16 = number of packets fully sent (header and data
//   counted separately), increments on last bit of HDR/DATA, saturates at 16'hFFFF, cleared by reset.
// - Undefined: port and counter absent; all other behaviour identical.
// TESTING
// - Reset, idle: no valid_i -> data_o=0, clk_en_o=0, level_o=0, ready_o=1 with enable_i=1.
// - hdr_i=64'hA5A5_0000_0000_0001, dlen=0, accept at A -> bit0 at A+2, 64 UIs clk_en_o=1, then 32 zero UIs, IDLE.
// - hdr + dlen=1 data_i=64'hFFFF_FFFF_1234_5678 -> header(64), gap(32), data 32'h12345678 then 32 zeros, gap(32).
// - Push 9 messages DEPTH=8 with serialiser busy -> ready_o=0 at level_o=8; all 8 sent in order, gaps exact.
// - dlen=3 -> err_o pulse one cycle, level_o unchanged, nothing transmitted.
// - Assert reset at header bit 20 with 3 queued -> data_o=0,clk_en_o=0 next cycle, level_o=0; (_EN) tx_count_o=0.

Source files
------------

// File: rtl/sb_tx_pkt_serializer_if.sv
// Message ingress interface for sb_tx_pkt_serializer.
//
// Handshake: a message transfers on a rising clk_100MHz edge where valid_i && ready_o.
// While valid_i is high and the message has not transferred, the source holds
// hdr_i, data_i and dlen_i stable. ready_o never depends on valid_i, so a source
// may wait for ready_o before raising valid_i, or raise valid_i first.
interface sb_tx_pkt_serializer_if #(
    parameter int PKT_W = 64
);
    logic [PKT_W-1:0] hdr_i;    // encoded header packet
    logic [63:0]      data_i;   // payload; [31:0] used when dlen_i = 1
    logic [1:0]       dlen_i;   // 0 = no data, 1 = 32b, 2 = 64b, 3 = illegal
    logic             valid_i;  // message valid
    logic             ready_o;  // block can accept a message this cycle

    // Source side (testbench / upstream logic)
    modport master (
        output hdr_i,
        output data_i,
        output dlen_i,
        output valid_i,
        input  ready_o
    );

    // Serializer side
    modport slave (
        input  hdr_i,
        input  data_i,
        input  dlen_i,
        input  valid_i,
        output ready_o
    );
endinterface

// File: rtl/sb_tx_pkt_serializer.sv
// Sideband transmitter: queues header + optional 32b/64b payload messages in a
// circular FIFO and sends each packet LSB first on one serial lane. Every packet
// is followed by GAP_UI quiet UIs. clk_en_o marks the UIs that carry packet bits
// so the pad wrapper can gate the forwarded sideband clock.
//
// Optional feature: define SB_TX_PKT_COUNT_EN to add tx_count_o, a saturating
// 16-bit count of packets fully sent (header and data packets each count once).
//
// PKT_W must be at least 64 so a 64b payload fits in one packet.
module sb_tx_pkt_serializer #(
    parameter int DEPTH  = 8,   // FIFO entries, power of 2, >= 2
    parameter int PKT_W  = 64,  // bits per serial packet
    parameter int GAP_UI = 32   // quiet UIs after every packet, >= 1
) (
    input  logic                     clk_100MHz,
    input  logic                     reset,        // synchronous, active-high
    sb_tx_pkt_serializer_if.slave    msg,
    input  logic                     enable_i,     // gates accept and new pops
    output logic                     data_o,       // serial data, registered
    output logic                     clk_en_o,     // high on packet-bit UIs only
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     err_o,        // dlen_i = 3 message dropped
`ifdef SB_TX_PKT_COUNT_EN
    output logic [15:0]              tx_count_o,
`endif
    output logic [1:0]               state_dbg_o   // current FSM state
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(PKT_W);
    localparam int GW = $clog2(GAP_UI + 1);
    localparam int EW = 2 + 64 + PKT_W;  // FIFO entry {dlen, data, hdr}

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t           state_q,   state_d;
    logic [AW:0]      wr_ptr_q,  wr_ptr_d;
    logic [AW:0]      rd_ptr_q,  rd_ptr_d;
    logic [PKT_W-1:0] shift_q,   shift_d;    // packet being serialised
    logic [PKT_W-1:0] payload_q, payload_d;  // payload waiting behind header
    logic             pend_q,    pend_d;     // payload_q still to be sent
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic             data_q,    data_d;
    logic             clk_en_q,  clk_en_d;
    logic             err_q,     err_d;
`ifdef SB_TX_PKT_COUNT_EN
    logic [15:0]      tx_cnt_q,  tx_cnt_d;
`endif

    // FIFO storage; contents need no reset because the pointers define validity
    logic [EW-1:0]    fifo_mem [DEPTH];

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [LW-1:0]    level;
    logic             fifo_empty;
    logic             fifo_full;
    logic             ready;
    logic             accept;
    logic             push;
    logic             pop;
    logic             pkt_phase;
    logic             bit_last;
    logic             gap_last;
    logic [EW-1:0]    wr_entry;
    logic [EW-1:0]    head;
    logic [PKT_W-1:0] head_hdr;
    logic [63:0]      head_data;
    logic [1:0]       head_dlen;

    // Payload packet as it goes on the wire: 32b payloads are zero-extended
    function automatic logic [PKT_W-1:0] widen_payload(input logic [1:0]  dlen,
                                                       input logic [63:0] data);
        logic [PKT_W-1:0] pkt;
        pkt = '0;
        if (dlen == 2'd1) begin
            pkt[31:0] = data[31:0];
        end else begin
            pkt[63:0] = data;
        end
        return pkt;
    endfunction

    assign level      = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (level == LW'(DEPTH));

    // Accept is closed during reset, while disabled and while full
    assign ready  = !reset && enable_i && !fifo_full;
    assign accept = msg.valid_i && ready;
    assign push   = accept && (msg.dlen_i != 2'd3);

    assign wr_entry  = {msg.dlen_i, msg.data_i, msg.hdr_i};
    assign head      = fifo_mem[rd_ptr_q[AW-1:0]];
    assign head_hdr  = head[PKT_W-1:0];
    assign head_data = head[PKT_W+63:PKT_W];
    assign head_dlen = head[EW-1:EW-2];

    assign pkt_phase = (state_q == ST_HDR) || (state_q == ST_DATA);
    assign bit_last  = (bit_cnt_q == BW'(PKT_W - 1));
    assign gap_last  = (gap_cnt_q == GW'(GAP_UI - 1));

    // A new entry is taken when idle, or at the end of a gap with nothing
    // pending, so back-to-back packets see exactly GAP_UI quiet UIs
    assign pop = enable_i && !fifo_empty &&
                 ((state_q == ST_IDLE) ||
                  ((state_q == ST_GAP) && gap_last && !pend_q));

    // ------------------------------------------------------------------
    // FSM state register and all datapath flops
    // ------------------------------------------------------------------
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            shift_q   <= '0;
            payload_q <= '0;
            pend_q    <= 1'b0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            data_q    <= 1'b0;
            clk_en_q  <= 1'b0;
            err_q     <= 1'b0;
`ifdef SB_TX_PKT_COUNT_EN
            tx_cnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            shift_q   <= shift_d;
            payload_q <= payload_d;
            pend_q    <= pend_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            data_q    <= data_d;
            clk_en_q  <= clk_en_d;
            err_q     <= err_d;
`ifdef SB_TX_PKT_COUNT_EN
            tx_cnt_q  <= tx_cnt_d;
`endif
        end
    end

    // FIFO write port
    always_ff @(posedge clk_100MHz) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= wr_entry;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR, ST_DATA: begin
                if (bit_last) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_last) begin
                    if (pend_q) begin
                        state_d = ST_DATA;
                    end else if (pop) begin
                        state_d = ST_HDR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM outputs and datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d  = wr_ptr_q + LW'(push);
        rd_ptr_d  = rd_ptr_q + LW'(pop);
        shift_d   = shift_q;
        payload_d = payload_q;
        pend_d    = pend_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;

        // Serial output stage: one register between shifter and pin
        data_d   = pkt_phase ? shift_q[0] : 1'b0;
        clk_en_d = pkt_phase;
        err_d    = accept && (msg.dlen_i == 2'd3);

        // Shifter: load header on pop, payload after the header's gap
        if (pop) begin
            shift_d   = head_hdr;
            payload_d = widen_payload(head_dlen, head_data);
            pend_d    = (head_dlen != 2'd0);
        end else if ((state_q == ST_GAP) && gap_last && pend_q) begin
            shift_d = payload_q;
            pend_d  = 1'b0;
        end else if (pkt_phase) begin
            shift_d = shift_q >> 1;
        end

        // Counters restart on every state entry (including GAP -> HDR)
        if (state_d != state_q) begin
            bit_cnt_d = '0;
            gap_cnt_d = '0;
        end else if (pkt_phase) begin
            bit_cnt_d = bit_cnt_q + BW'(1);
        end else if (state_q == ST_GAP) begin
            gap_cnt_d = gap_cnt_q + GW'(1);
        end

`ifdef SB_TX_PKT_COUNT_EN
        // Count a packet on its last bit; hold at all-ones
        tx_cnt_d = tx_cnt_q;
        if (pkt_phase && bit_last && (tx_cnt_q != 16'hFFFF)) begin
            tx_cnt_d = tx_cnt_q + 16'd1;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Port drive
    // ------------------------------------------------------------------
    assign msg.ready_o = ready;
    assign data_o      = data_q;
    assign clk_en_o    = clk_en_q;
    assign err_o       = err_q;
    assign level_o     = level;
    assign busy_o      = (state_q != ST_IDLE) || !fifo_empty;
    assign state_dbg_o = state_q;
`ifdef SB_TX_PKT_COUNT_EN
    assign tx_count_o  = tx_cnt_q;
`endif

endmodule

// File: tb/tb_sb_tx_pkt_serializer.sv
// Testbench for sb_tx_pkt_serializer: directed steps plus a randomized message
// stream. A line monitor reassembles packets from data_o/clk_en_o and compares
// them, in order, with the packets the bench expects from the accepted messages.
module tb_sb_tx_pkt_serializer;
    localparam int DEPTH  = 8;
    localparam int PKT_W  = 64;
    localparam int GAP_UI = 32;
    localparam int LW     = $clog2(DEPTH) + 1;

    // ---------------- clock / reset ----------------
    logic clk_100MHz = 1'b0;
    logic reset      = 1'b1;
    logic enable_i   = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    logic          data_o;
    logic          clk_en_o;
    logic          busy_o;
    logic          err_o;
    logic [LW-1:0] level_o;
    logic [1:0]    state_dbg_o;
`ifdef SB_TX_PKT_COUNT_EN
    logic [15:0]   tx_count_o;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [PKT_W-1:0] exp_q[$];   // packets expected on the line, in order
    int               gap_q[$];   // quiet UIs observed before each packet

    sb_tx_pkt_serializer_if #(.PKT_W(PKT_W)) msg_if ();

    sb_tx_pkt_serializer #(
        .DEPTH (DEPTH),
        .PKT_W (PKT_W),
        .GAP_UI(GAP_UI)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .msg        (msg_if.slave),
        .enable_i   (enable_i),
        .data_o     (data_o),
        .clk_en_o   (clk_en_o),
        .busy_o     (busy_o),
        .level_o    (level_o),
        .err_o      (err_o),
`ifdef SB_TX_PKT_COUNT_EN
        .tx_count_o (tx_count_o),
`endif
        .state_dbg_o(state_dbg_o)
    );

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [PKT_W-1:0] obs,
                         input logic [PKT_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- line monitor ----------------
    logic [PKT_W-1:0] rx_sr;
    int  rx_n     = 0;
    int  gap_run  = 0;
    bit  seen_pkt = 1'b0;

    always @(negedge clk_100MHz) begin
        if (reset) begin
            rx_n     = 0;
            gap_run  = 0;
            seen_pkt = 1'b0;
        end else if (clk_en_o) begin
            if (rx_n == 0 && seen_pkt) gap_q.push_back(gap_run);
            rx_sr[rx_n] = data_o;
            rx_n++;
            if (rx_n == PKT_W) begin
                check("pkt_expected", PKT_W'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("pkt_content", rx_sr, exp_q.pop_front());
                rx_n     = 0;
                gap_run  = 0;
                seen_pkt = 1'b1;
            end
        end else begin
            check("quiet_data_zero", data_o, 0);
            check("pkt_contiguous", rx_n, 0);
            rx_n = 0;
            gap_run++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk_100MHz);
        #1;
    endtask

    function automatic logic [PKT_W-1:0] payload_pkt(input logic [1:0] dl,
                                                     input logic [63:0] d);
        logic [PKT_W-1:0] p;
        p = '0;
        if (dl == 2'd1) p = PKT_W'(d[31:0]);
        else            p = PKT_W'(d);
        return p;
    endfunction

    // Offer one message; returns just after the accepting edge
    task automatic send(input logic [PKT_W-1:0] h, input logic [63:0] d,
                        input logic [1:0] dl, input int budget);
        bit ok;
        bit rdy;
        ok = 1'b0;
        msg_if.hdr_i   = h;
        msg_if.data_i  = d;
        msg_if.dlen_i  = dl;
        msg_if.valid_i = 1'b1;
        for (int c = 0; c < budget && !ok; c++) begin
            #1;
            rdy = msg_if.ready_o;
            step();
            if (rdy) ok = 1'b1;
        end
        msg_if.valid_i = 1'b0;
        check("accept_in_budget", ok, 1);
        if (ok) begin
            if (dl != 2'd3) begin
                exp_q.push_back(h);
                if (dl != 2'd0) exp_q.push_back(payload_pkt(dl, d));
            end
            check("err_pulse", err_o, (dl == 2'd3));
        end
    endtask

    task automatic expect_serial(input string tag, input logic [PKT_W-1:0] pkt);
        for (int i = 0; i < PKT_W; i++) begin
            check({tag, "_ce"}, clk_en_o, 1);
            check({tag, "_bit"}, data_o, pkt[i]);
            step();
        end
    endtask

    task automatic expect_gap(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_ce"}, clk_en_o, 0);
            check({tag, "_data"}, data_o, 0);
            step();
        end
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            if (!busy_o) done = 1'b1;
            else step();
        end
        check("idle_in_budget", done, 1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [PKT_W-1:0] h;
        logic [63:0]      d;
        logic [1:0]       dl;

        msg_if.hdr_i   = '0;
        msg_if.data_i  = '0;
        msg_if.dlen_i  = '0;
        msg_if.valid_i = 1'b0;
        reset    = 1'b1;
        enable_i = 1'b1;
        repeat (3) step();

        // Reset held: everything quiet, no accept
        check("rst_ready", msg_if.ready_o, 0);
        check("rst_level", level_o, 0);
        check("rst_data", data_o, 0);
        check("rst_clk_en", clk_en_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_err", err_o, 0);
        reset = 1'b0;
        step();

        // Idle after reset
        check("idle_ready", msg_if.ready_o, 1);
        check("idle_level", level_o, 0);
        check("idle_data", data_o, 0);
        check("idle_clk_en", clk_en_o, 0);
        check("idle_busy", busy_o, 0);
`ifdef SB_TX_PKT_COUNT_EN
        check("idle_tx_count", tx_count_o, 0);
`endif

        // Header only: bit0 two edges after accept, 64 UIs, 32 quiet, idle
        send(64'hA5A5_0000_0000_0001, 64'h0, 2'd0, 10);
        step();
        check("lat_a1_clk_en", clk_en_o, 0);
        step();
        expect_serial("lat_hdr", 64'hA5A5_0000_0000_0001);
        expect_gap("lat_gap", GAP_UI);
        check("lat_idle_busy", busy_o, 0);
`ifdef SB_TX_PKT_COUNT_EN
        check("lat_tx_count", tx_count_o, 1);
`endif

        // Header + 32b payload
        send(64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_1234_5678, 2'd1, 10);
        step();
        check("d32_a1_clk_en", clk_en_o, 0);
        step();
        expect_serial("d32_hdr", 64'h0123_4567_89AB_CDEF);
        expect_gap("d32_gap0", GAP_UI);
        expect_serial("d32_data", 64'h0000_0000_1234_5678);
        expect_gap("d32_gap1", GAP_UI);
        check("d32_idle_busy", busy_o, 0);
`ifdef SB_TX_PKT_COUNT_EN
        check("d32_tx_count", tx_count_o, 3);
`endif

        // Illegal length: dropped with a one-cycle error pulse
        send(64'hDEAD_BEEF_DEAD_BEEF, 64'h1, 2'd3, 10);
        check("ill_level", level_o, 0);
        step();
        check("ill_err_clear", err_o, 0);
        repeat (4) step();
        check("ill_clk_en", clk_en_o, 0);
        check("ill_busy", busy_o, 0);

        // Enable low: in-flight message completes, queued one waits
        send(64'h1111_2222_3333_4444, 64'h0, 2'd0, 10);
        send(64'h5555_6666_7777_8888, 64'h0, 2'd0, 10);
        enable_i = 1'b0;
        #1;
        check("dis_ready", msg_if.ready_o, 0);
        repeat (150) step();
        check("dis_level", level_o, 1);
        check("dis_busy", busy_o, 1);
        check("dis_clk_en", clk_en_o, 0);
        enable_i = 1'b1;
        wait_idle(400);
        check("dis_drained", exp_q.size(), 0);

        // Fill the FIFO behind a long message, then one more
        send(64'hCAFE_0000_0000_0000, 64'hF0F0_0F0F_AAAA_5555, 2'd2, 10);
        repeat (3) step();
        gap_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            send({$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 2)), 10);
            check("fill_level", level_o, i + 1);
        end
        check("full_ready", msg_if.ready_o, 0);
        msg_if.hdr_i   = 64'h9999_0000_0000_0009;
        msg_if.valid_i = 1'b1;
        repeat (5) step();
        check("full_hold_level", level_o, DEPTH);
        send(64'h9999_0000_0000_0009, 64'h0, 2'd0, 400);
        check("full_refill_level", level_o, DEPTH);
        wait_idle(4000);
        check("fill_drained", exp_q.size(), 0);
        check("fill_gap_count_nonzero", PKT_W'(gap_q.size() >= 9), 1);
        foreach (gap_q[i]) check("fill_gap_exact", gap_q[i], GAP_UI);

        // Random message stream
        gap_q.delete();
        for (int n = 0; n < 30; n++) begin
            h  = {$urandom, $urandom};
            d  = {$urandom, $urandom};
            dl = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            send(h, d, dl, 400);
            repeat ($urandom_range(0, 4)) step();
        end
        wait_idle(20000);
        check("rand_drained", exp_q.size(), 0);
        foreach (gap_q[i]) check("rand_gap_min", PKT_W'(gap_q[i] >= GAP_UI), 1);

        // Reset in the middle of a header with 3 messages queued
        send(64'h0F0F_F0F0_1234_ABCD, 64'h0, 2'd0, 10);
        for (int i = 0; i < 3; i++) send({$urandom, $urandom}, 64'h0, 2'd0, 10);
        repeat (19) step();
        check("mid_level", level_o, 3);
        check("mid_clk_en", clk_en_o, 1);
        check("mid_bit20", data_o, 1'b1);  // bit 20 of 0x1234_ABCD
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_ready", msg_if.ready_o, 0);
        step();
        check("mid_rst_data", data_o, 0);
        check("mid_rst_clk_en", clk_en_o, 0);
        check("mid_rst_level", level_o, 0);
        check("mid_rst_busy", busy_o, 0);
`ifdef SB_TX_PKT_COUNT_EN
        check("mid_rst_tx_count", tx_count_o, 0);
`endif
        reset = 1'b0;
        repeat (100) step();
        check("post_rst_clk_en", clk_en_o, 0);
        check("post_rst_ready", msg_if.ready_o, 1);
        check("post_rst_busy", busy_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Time limit so the run always ends on its own
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
